param_flag_fifo: RTL

PARAM_FLAG_FIFO -- requirements
Module: param_flag_fifo

---
 rtl/param_flag_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/param_flag_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-2) depth, registered status flags,
// sticky overflow/underflow errors and a selectable registered or fall-through read port.
module param_flag_fifo #(
  parameter int FWIDTH    = 8,
  parameter int FDEPTH    = 1024,
  parameter int FCWIDTH   = 10,
  parameter int AFULL_TH  = 1000,
  parameter int AEMPTY_TH = 16,
  parameter int FWFT      = 0
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic [FWIDTH-1:0]   Data_In,
  input  logic                FClrN,
  input  logic                FInN,
  input  logic                FOutN,
  output logic [FWIDTH-1:0]   F_Data,
  output logic [FCWIDTH:0]    F_Count,
  output logic                F_FullN,
  output logic                F_EmptyN,
  output logic                F_AFullN,
  output logic                F_AEmptyN,
  output logic                F_OvfN,
  output logic                F_UdfN
);

  localparam logic [FCWIDTH:0]   DepthC   = (FCWIDTH+1)'(FDEPTH);
  localparam logic [FCWIDTH:0]   AFullC   = (FCWIDTH+1)'(AFULL_TH);
  localparam logic [FCWIDTH:0]   AEmptyC  = (FCWIDTH+1)'(AEMPTY_TH);
  localparam logic [FCWIDTH-1:0] LastPtrC = FCWIDTH'(FDEPTH - 1);

  logic [FWIDTH-1:0]  mem [FDEPTH];
  logic [FCWIDTH-1:0] wrPtr;
  logic [FCWIDTH-1:0] rdPtr;
  logic [FCWIDTH:0]   cntNxt;
  logic               wrAcc;
  logic               rdAcc;

  // Pointers wrap at the last real slot so non power-of-2 depths never index past the array.
  function automatic logic [FCWIDTH-1:0] incPtr(input logic [FCWIDTH-1:0] p);
    return (p == LastPtrC) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still takes a write when a read frees the slot at the same edge.
  always_comb begin
    wrAcc  = RstN && FClrN && !FInN && ((F_Count < DepthC) || !FOutN);
    rdAcc  = RstN && FClrN && !FOutN && (F_Count != '0);
    cntNxt = F_Count;
    case ({wrAcc, rdAcc})
      2'b10:   cntNxt = F_Count + 1'b1;
      2'b01:   cntNxt = F_Count - 1'b1;
      default: cntNxt = F_Count;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      F_Count   <= '0;
      F_FullN   <= 1'b1;
      F_EmptyN  <= 1'b0;
      F_AFullN  <= 1'b1;
      F_AEmptyN <= 1'b0;
      F_OvfN    <= 1'b1;
      F_UdfN    <= 1'b1;
    end else if (!FClrN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      F_Count   <= '0;
      F_FullN   <= 1'b1;
      F_EmptyN  <= 1'b0;
      F_AFullN  <= 1'b1;
      F_AEmptyN <= 1'b0;
      F_OvfN    <= 1'b1;
      F_UdfN    <= 1'b1;
    end else begin
      if (wrAcc) wrPtr <= incPtr(wrPtr);
      if (rdAcc) rdPtr <= incPtr(rdPtr);
      F_Count   <= cntNxt;
      F_FullN   <= !(cntNxt == DepthC);
      F_EmptyN  <= !(cntNxt == '0);
      F_AFullN  <= !(cntNxt >= AFullC);
      F_AEmptyN <= !(cntNxt <= AEmptyC);
      if (!FInN && !wrAcc)  F_OvfN <= 1'b0;
      if (!FOutN && !rdAcc) F_UdfN <= 1'b0;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge Clk) begin
    if (wrAcc) mem[wrPtr] <= Data_In;
  end

  generate
    if (FWFT != 0) begin : gFwft
      assign F_Data = F_EmptyN ? mem[rdPtr] : '0;
    end else begin : gReg
      always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)       F_Data <= '0;
        else if (!FClrN) F_Data <= '0;
        else if (rdAcc)  F_Data <= mem[rdPtr];
      end
    end
  endgenerate

endmodule
